tcm_port_arbiter: RTL

//  Shares the single TCM B-port (disk/data memory, 16-bit byte address, 128-bit lines,

---
 rtl/tcm_port_arbiter.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/tcm_port_arbiter.sv
// -----------------------------------------------------------------------------
// tcm_port_arbiter
//
// Shares the single TCM B-port between NREQ masters (for example 0=LSU,
// 1=SDHCI DMA, 2=LPC engine).  Masters are served round-robin with one
// transaction in flight.  Address and write data are latched at grant time,
// and read data is returned through a register.  A watchdog completes a hung
// transaction with an error flag.
//
// Ports
//   clk, rst_n          clock (posedge) and asynchronous active-low reset
//   m_rd_req/m_wr_req   per-master level requests, held until m_finish
//   m_addr/m_wdata      per-master address/line, master i at [i*W +: W]
//   m_finish            one-cycle completion pulse to the granted master
//   m_err               high with m_finish when the watchdog aborted the op
//   m_rdata             last read line, held until the next read completes
//   s_rd_req/s_wr_req   TCM B-port requests
//   s_addr/s_wdata      TCM B-port address / write line (latched)
//   s_finish/s_rdata    TCM B-port completion pulse / read line
//   grant_id            index of the current/last granted master
//   busy                high whenever the arbiter is not idle
// -----------------------------------------------------------------------------
module tcm_port_arbiter #(
  parameter int NREQ       = 3,
  parameter int AW         = 16,
  parameter int DW         = 128,
  parameter int WAIT_LIMIT = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    m_rd_req,
  input  logic [NREQ-1:0]    m_wr_req,
  input  logic [NREQ*AW-1:0] m_addr,
  input  logic [NREQ*DW-1:0] m_wdata,
  output logic [NREQ-1:0]    m_finish,
  output logic               m_err,
  output logic [DW-1:0]      m_rdata,
  output logic               s_rd_req,
  output logic               s_wr_req,
  output logic [AW-1:0]      s_addr,
  output logic [DW-1:0]      s_wdata,
  input  logic               s_finish,
  input  logic [DW-1:0]      s_rdata,
  output logic [2:0]         grant_id,
  output logic               busy
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RELEASE
  } state_t;

  state_t          state;
  logic [2:0]      ptr;
  logic [3:0]      wdog;
  logic [NREQ-1:0] req;
  logic            pick_vld;
  logic [2:0]      pick;
  logic [NREQ-1:0] grant_onehot;

  assign req = m_rd_req | m_wr_req;

  // Round-robin pick.  Scanning from the farthest candidate down to ptr+1
  // lets the nearest requester after the pointer overwrite the others.
  always_comb begin
    pick_vld = 1'b0;
    pick     = '0;
    for (int k = NREQ; k >= 1; k--) begin
      int idx;
      idx = (int'(ptr) + k) % NREQ;
      if (req[idx]) begin
        pick_vld = 1'b1;
        pick     = 3'(idx);
      end
    end
  end

  always_comb begin
    grant_onehot = '0;
    for (int i = 0; i < NREQ; i++) begin
      grant_onehot[i] = (grant_id == 3'(i));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      ptr      <= 3'(NREQ - 1);
      wdog     <= '0;
      m_finish <= '0;
      m_err    <= 1'b0;
      m_rdata  <= '0;
      s_rd_req <= 1'b0;
      s_wr_req <= 1'b0;
      s_addr   <= '0;
      s_wdata  <= '0;
      grant_id <= '0;
      busy     <= 1'b0;
    end else begin
      // Completion flags are single-cycle pulses.
      m_finish <= '0;
      m_err    <= 1'b0;
      case (state)
        // Grant: latch the winner's operands and raise the TCM request
        // right away so it is visible in the ISSUE cycle.  A master asking
        // for both read and write gets the write.
        ST_IDLE: begin
          if (pick_vld) begin
            grant_id <= pick;
            ptr      <= pick;
            s_addr   <= m_addr[int'(pick)*AW +: AW];
            s_wdata  <= m_wdata[int'(pick)*DW +: DW];
            s_wr_req <= m_wr_req[pick];
            s_rd_req <= ~m_wr_req[pick];
            busy     <= 1'b1;
            state    <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          wdog  <= '0;
          state <= ST_WAIT;
        end
        // Requests and operands stay stable until the TCM finishes or the
        // watchdog fires.  A real finish takes priority over the watchdog.
        ST_WAIT: begin
          wdog <= wdog + 4'd1;
          if (s_finish) begin
            s_rd_req <= 1'b0;
            s_wr_req <= 1'b0;
            m_finish <= grant_onehot;
            if (s_rd_req) begin
              m_rdata <= s_rdata;
            end
            state <= ST_RELEASE;
          end else if (wdog == 4'(WAIT_LIMIT)) begin
            s_rd_req <= 1'b0;
            s_wr_req <= 1'b0;
            m_finish <= grant_onehot;
            m_err    <= 1'b1;
            state    <= ST_RELEASE;
          end
        end
        // The m_finish pulse is visible here.  No arbitration happens in
        // this cycle, so the served master's still-high request is ignored.
        ST_RELEASE: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
